parity_check_stream: RTL and testbench



---
 rtl/parity_check_stream.sv | 123 ++++++++++++
 tb/tb_parity_check_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_check_stream.sv
// Streaming parity checker: per-frame error flag, errored-word count and word count.
// Optional sticky error output enabled with `define PARITY_CHECK_STICKY_EN.
module parity_check_stream #(
    parameter int DATA_W    = 4,
    parameter int MAX_WORDS = 8,
    parameter int CNT_W     = 4,
    localparam int WORDS_W  = $clog2(MAX_WORDS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               odd_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               parity_bit,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               parity_checkbit,
    output logic [CNT_W-1:0]   word_err_cnt,
    output logic [WORDS_W-1:0] frame_words,
`ifdef PARITY_CHECK_STICKY_EN
    input  logic               sticky_clr,
    output logic               sticky_err,
`endif
    output logic               frame_trunc
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    state_t               state_q, state_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORDS_W-1:0]   words_q, words_d;
    logic                 trunc_q, trunc_d;
    logic                 mode_q, mode_d;
    logic                 mode_eff;
    logic                 word_err;
    logic                 beat;
    logic                 hit;
    logic [WORDS_W-1:0]   words_inc;

    assign in_ready        = !rst && (state_q != REPORT);
    assign out_valid       = (state_q == REPORT);
    assign parity_checkbit = err_q;
    assign word_err_cnt    = cnt_q;
    assign frame_words     = words_q;
    assign frame_trunc     = trunc_q;

    // First beat is checked against the mode being latched with it.
    assign mode_eff  = (state_q == IDLE) ? odd_mode : mode_q;
    assign word_err  = (^data_in) ^ parity_bit ^ mode_eff;
    assign beat      = in_valid && in_ready;
    assign words_inc = words_q + WORDS_W'(1);
    assign hit       = (words_inc == WORDS_W'(MAX_WORDS));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        trunc_d = trunc_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    mode_d  = odd_mode;
                    err_d   = word_err;
                    cnt_d   = CNT_W'(word_err);
                    words_d = WORDS_W'(1);
                    trunc_d = (MAX_WORDS == 1) && !in_last;
                    if (in_last || (MAX_WORDS == 1)) state_d = REPORT;
                    else state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    err_d   = err_q | word_err;
                    if (word_err && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
                    words_d = words_inc;
                    trunc_d = hit && !in_last;
                    if (in_last || hit) state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            words_q <= '0;
            trunc_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            trunc_q <= trunc_d;
            mode_q  <= mode_d;
        end
    end

`ifdef PARITY_CHECK_STICKY_EN
    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) sticky_err <= 1'b0;
        else if (out_valid && out_ready && err_q) sticky_err <= 1'b1;
        else if (sticky_clr) sticky_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_parity_check_stream.sv
// Directed frame-level bench for parity_check_stream (DATA_W=4, MAX_WORDS=8, CNT_W=2).
module tb_parity_check_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       odd_mode;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_in;
    logic       parity_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       parity_checkbit;
    logic [1:0] word_err_cnt;
    logic [3:0] frame_words;
    logic       frame_trunc;
`ifdef PARITY_CHECK_STICKY_EN
    logic       sticky_clr;
    logic       sticky_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_check_stream #(
        .DATA_W(4),
        .MAX_WORDS(8),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .odd_mode(odd_mode),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .parity_bit(parity_bit),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .parity_checkbit(parity_checkbit),
        .word_err_cnt(word_err_cnt),
        .frame_words(frame_words),
`ifdef PARITY_CHECK_STICKY_EN
        .sticky_clr(sticky_clr),
        .sticky_err(sticky_err),
`endif
        .frame_trunc(frame_trunc)
    );

    typedef struct {
        string       name;
        logic        mode0;
        logic        mode1;
        int          n;
        logic [31:0] data;
        logic [7:0]  par;
        logic        last;
        logic        e_err;
        logic [1:0]  e_cnt;
        logic [3:0]  e_words;
        logic        e_trunc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic m, input logic [3:0] d,
                        input logic p, input logic l);
        odd_mode   = m;
        data_in    = d;
        parity_bit = p;
        in_last    = l;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic chk_result(input string name, input logic e_err,
                              input logic [1:0] e_cnt,
                              input logic [3:0] e_words,
                              input logic e_trunc);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".err"}, 32'(parity_checkbit), 32'(e_err));
        chk({name, ".cnt"}, 32'(word_err_cnt), 32'(e_cnt));
        chk({name, ".words"}, 32'(frame_words), 32'(e_words));
        chk({name, ".trunc"}, 32'(frame_trunc), 32'(e_trunc));
    endtask

    task automatic handoff(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, ".vlow"}, 32'(out_valid), 32'd0);
        chk({name, ".rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"even_ok", 1'b0, 1'b0, 4, 32'h0000_0F31, 8'b0000_0001,
                    1'b1, 1'b0, 2'd0, 4'd4, 1'b0};
        vecs[1] = '{"even_err", 1'b0, 1'b0, 4, 32'h0000_8762, 8'b0000_1011,
                    1'b1, 1'b1, 2'd2, 4'd4, 1'b0};
        vecs[2] = '{"odd_hold", 1'b1, 1'b0, 2, 32'h0000_0010, 8'b0000_0001,
                    1'b1, 1'b0, 2'd0, 4'd2, 1'b0};
        vecs[3] = '{"sat", 1'b0, 1'b0, 6, 32'h0011_1111, 8'b0000_0000,
                    1'b1, 1'b1, 2'd3, 4'd6, 1'b0};
        vecs[4] = '{"last_at_max", 1'b0, 1'b0, 8, 32'h0000_0000, 8'b0000_0000,
                    1'b1, 1'b0, 2'd0, 4'd8, 1'b0};
        vecs[5] = '{"single_odd", 1'b1, 1'b1, 1, 32'h0000_0003, 8'b0000_0000,
                    1'b1, 1'b1, 2'd1, 4'd1, 1'b0};

        rst        = 1'b1;
        odd_mode   = 1'b0;
        in_valid   = 1'b0;
        data_in    = 4'h0;
        parity_bit = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
`ifdef PARITY_CHECK_STICKY_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.err", 32'(parity_checkbit), 32'd0);
        chk("rst.cnt", 32'(word_err_cnt), 32'd0);
        chk("rst.words", 32'(frame_words), 32'd0);
        chk("rst.trunc", 32'(frame_trunc), 32'd0);
`ifdef PARITY_CHECK_STICKY_EN
        chk("rst.sticky", 32'(sticky_err), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                beat((i == 0) ? vecs[v].mode0 : vecs[v].mode1,
                     vecs[v].data[i*4 +: 4], vecs[v].par[i],
                     vecs[v].last && (i == vecs[v].n - 1));
                if (i < vecs[v].n - 1)
                    chk({vecs[v].name, ".mid_valid"}, 32'(out_valid), 32'd0);
            end
            chk_result(vecs[v].name, vecs[v].e_err, vecs[v].e_cnt,
                       vecs[v].e_words, vecs[v].e_trunc);
            handoff(vecs[v].name);
        end

`ifdef PARITY_CHECK_STICKY_EN
        chk("sticky.set", 32'(sticky_err), 32'd1);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("sticky.clr", 32'(sticky_err), 32'd0);
`endif

        // Truncation at MAX_WORDS, then 5 cycles of backpressure.
        for (int i = 0; i < 8; i++) beat(1'b0, 4'h0, 1'b0, 1'b0);
        chk_result("trunc", 1'b0, 2'd0, 4'd8, 1'b1);
        in_valid = 1'b1;
        in_last  = 1'b1;
        data_in  = 4'h1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk_result("bp", 1'b0, 2'd0, 4'd8, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        chk("bp.handoff", 32'(out_valid), 32'd0);
        chk("bp.ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp.no_accept", 32'(out_valid), 32'd0);

        // Reset mid-frame discards the partial frame.
        beat(1'b0, 4'h1, 1'b0, 1'b0);
        beat(1'b0, 4'h1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mrst.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.words", 32'(frame_words), 32'd0);
        beat(1'b0, 4'h1, 1'b1, 1'b1);
        chk_result("mrst", 1'b0, 2'd0, 4'd1, 1'b0);
        handoff("mrst");
`ifdef PARITY_CHECK_STICKY_EN
        chk("mrst.sticky", 32'(sticky_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
